// File: rtl/even_parity_frame_pkg.sv
// Shared types, line levels and parity helper for the even-parity frame transmitter.
// Words up to MAX_DATA_W bits are supported by the parity helper.
package even_parity_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  localparam logic TX_IDLE  = 1'b1;
  localparam logic TX_START = 1'b0;
  localparam logic TX_STOP  = 1'b1;

  localparam int MAX_DATA_W = 64;

  // Zero-extension does not change the XOR reduction, so narrower words are widened first.
  function automatic logic even_parity(input logic [MAX_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/even_parity_frame_tx_bit_timer.sv
// Bit-slot timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each slot.
// slot_end_next is the same flag evaluated on the next count, for registered consumers.
module even_parity_frame_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic slot_end,
  output logic slot_end_next
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign slot_end      = (cnt_q == LAST);
  assign slot_end_next = (cnt_d == LAST);

endmodule

// File: rtl/even_parity_frame_tx.sv
// Even-parity serial framer: start bit, DATA_W data bits LSB-first, parity, stop bit(s).
// Define TWO_STOP_EN to emit two stop bits per frame instead of one.
module even_parity_frame_tx
  import even_parity_frame_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic [IW-1:0]     bit_idx_q, bit_idx_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              stop_last_q, stop_last_d;

  logic                  handshake;
  logic                  slot_end;
  logic                  slot_end_next;
  logic [MAX_DATA_W-1:0] in_data_ext;

  assign in_ready    = (state_q == ST_IDLE) & ~rst;
  assign handshake   = in_valid & in_ready;
  assign in_data_ext = MAX_DATA_W'(in_data);

  even_parity_frame_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk          (clk),
    .rst          (rst),
    .clear        (handshake),
    .slot_end     (slot_end),
    .slot_end_next(slot_end_next)
  );

`ifdef TWO_STOP_EN
  logic stop_idx_q, stop_idx_d;
  assign stop_last_q = stop_idx_q;
  assign stop_last_d = stop_idx_d;
`else
  assign stop_last_q = 1'b1;
  assign stop_last_d = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    bit_idx_d = bit_idx_q;
`ifdef TWO_STOP_EN
    stop_idx_d = stop_idx_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          state_d = ST_START;
          shreg_d = in_data;
          par_d   = even_parity(in_data_ext);
        end
      end
      ST_START: begin
        if (slot_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (slot_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == LAST_IDX) begin
            state_d = ST_PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (slot_end) begin
          state_d = ST_STOP;
`ifdef TWO_STOP_EN
          stop_idx_d = 1'b0;
`endif
        end
      end
      ST_STOP: begin
        if (slot_end) begin
          if (stop_last_q) begin
            state_d = ST_IDLE;
          end else begin
`ifdef TWO_STOP_EN
            stop_idx_d = 1'b1;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level and status are derived from the next state so they land in flops.
  always_comb begin
    tx_d = TX_IDLE;
    unique case (state_d)
      ST_START:  tx_d = TX_START;
      ST_DATA:   tx_d = shreg_d[0];
      ST_PARITY: tx_d = par_d;
      ST_STOP:   tx_d = TX_STOP;
      default:   tx_d = TX_IDLE;
    endcase
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_STOP) & stop_last_d & slot_end_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      bit_idx_q    <= '0;
      tx_q         <= TX_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef TWO_STOP_EN
      stop_idx_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      bit_idx_q    <= bit_idx_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef TWO_STOP_EN
      stop_idx_q   <= stop_idx_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
